// File: rtl/multi_cycle_cpu.sv
// multi_cycle_cpu: multi-cycle MIPS-I subset core with one unified
// instruction/data memory (instance i_ram, array mem). Each instruction
// walks a small FSM, one state per clock. Register file, PC and IR are
// exported for debug observation.

// Unified word memory: combinational read, synchronous write, no reset so
// preloaded contents survive a CPU reset.
module multi_cycle_cpu_ram #(
  parameter int MEM_DEPTH = 1024,
  parameter int ADDR_W    = $clog2(MEM_DEPTH)
) (
  input  logic              clk,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [31:0]       i_wdata,
  output logic [31:0]       o_rdata
);

  logic [31:0] mem [0:MEM_DEPTH-1];

  // Synchronous word write
  always_ff @(posedge clk) begin
    if (i_we) begin
      mem[i_addr] <= i_wdata;
    end
  end

  assign o_rdata = mem[i_addr];

endmodule

module multi_cycle_cpu #(
  parameter int MEM_DEPTH = 1024
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] regs_debug [0:31],
  output logic [31:0] pc_debug,
  output logic [31:0] instr_debug
);

  localparam int AW = $clog2(MEM_DEPTH);

  // Opcodes
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  // R-type function codes
  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_SRL  = 6'h02;
  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUB  = 6'h22;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_XOR  = 6'h26;
  localparam logic [5:0] FN_NOR  = 6'h27;
  localparam logic [5:0] FN_SLT  = 6'h2A;
  localparam logic [5:0] FN_SLTU = 6'h2B;

  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_MEMADR,
    S_MEMRD,
    S_MEMWB,
    S_MEMWR,
    S_RTYPEEX,
    S_RTYPEWB,
    S_ITYPEEX,
    S_ITYPEWB,
    S_BRANCH,
    S_JUMP
  } state_t;

  state_t r_state;
  state_t w_state_next;

  logic [31:0] r_pc;
  logic [31:0] r_ir;
  logic [31:0] r_a;
  logic [31:0] r_b;
  logic [31:0] r_aluout;
  logic [31:0] r_mdr;
  logic [31:0] r_regs [0:31];

  // Instruction fields
  logic [5:0]  w_op;
  logic [4:0]  w_rs;
  logic [4:0]  w_rt;
  logic [4:0]  w_rd;
  logic [4:0]  w_shamt;
  logic [5:0]  w_funct;
  logic [15:0] w_imm;
  logic [25:0] w_target;
  logic [31:0] w_imm_sext;
  logic [31:0] w_imm_zext;

  assign w_op       = r_ir[31:26];
  assign w_rs       = r_ir[25:21];
  assign w_rt       = r_ir[20:16];
  assign w_rd       = r_ir[15:11];
  assign w_shamt    = r_ir[10:6];
  assign w_funct    = r_ir[5:0];
  assign w_imm      = r_ir[15:0];
  assign w_target   = r_ir[25:0];
  assign w_imm_sext = {{16{w_imm[15]}}, w_imm};
  assign w_imm_zext = {16'h0000, w_imm};

  // Combinational register file reads ($0 is never written, so reads 0)
  logic [31:0] w_rs_val;
  logic [31:0] w_rt_val;
  assign w_rs_val = r_regs[w_rs];
  assign w_rt_val = r_regs[w_rt];

  // Memory interface
  logic          w_mem_we;
  logic [AW-1:0] w_mem_addr;
  logic [31:0]   w_mem_rdata;

  multi_cycle_cpu_ram #(
    .MEM_DEPTH (MEM_DEPTH),
    .ADDR_W    (AW)
  ) i_ram (
    .clk     (clk),
    .i_we    (w_mem_we),
    .i_addr  (w_mem_addr),
    .i_wdata (r_b),
    .o_rdata (w_mem_rdata)
  );

  // Register write port
  logic        w_reg_we;
  logic [4:0]  w_reg_waddr;
  logic [31:0] w_reg_wdata;

  // Which R-type functs are implemented; anything else is a NOP
  logic w_rtype_ok;
  always_comb begin
    w_rtype_ok = 1'b0;
    case (w_funct)
      FN_SLL, FN_SRL, FN_ADD, FN_ADDU, FN_SUB, FN_SUBU,
      FN_AND, FN_OR, FN_XOR, FN_NOR, FN_SLT, FN_SLTU: w_rtype_ok = 1'b1;
      default: w_rtype_ok = 1'b0;
    endcase
  end

  // R-type ALU: add/sub never trap, shifts act on rt (B) by shamt
  logic [31:0] w_alu_r;
  always_comb begin
    w_alu_r = 32'h0;
    case (w_funct)
      FN_SLL:          w_alu_r = r_b << w_shamt;
      FN_SRL:          w_alu_r = r_b >> w_shamt;
      FN_ADD, FN_ADDU: w_alu_r = r_a + r_b;
      FN_SUB, FN_SUBU: w_alu_r = r_a - r_b;
      FN_AND:          w_alu_r = r_a & r_b;
      FN_OR:           w_alu_r = r_a | r_b;
      FN_XOR:          w_alu_r = r_a ^ r_b;
      FN_NOR:          w_alu_r = ~(r_a | r_b);
      FN_SLT:          w_alu_r = {31'h0, ($signed(r_a) < $signed(r_b))};
      FN_SLTU:         w_alu_r = {31'h0, (r_a < r_b)};
      default:         w_alu_r = 32'h0;
    endcase
  end

  // I-type ALU: logical ops zero-extend, the rest sign-extend
  logic [31:0] w_alu_i;
  always_comb begin
    w_alu_i = 32'h0;
    case (w_op)
      OP_ADDI, OP_ADDIU: w_alu_i = r_a + w_imm_sext;
      OP_SLTI:           w_alu_i = {31'h0, ($signed(r_a) < $signed(w_imm_sext))};
      OP_ANDI:           w_alu_i = r_a & w_imm_zext;
      OP_ORI:            w_alu_i = r_a | w_imm_zext;
      OP_XORI:           w_alu_i = r_a ^ w_imm_zext;
      OP_LUI:            w_alu_i = {w_imm, 16'h0000};
      default:           w_alu_i = 32'h0;
    endcase
  end

  logic w_branch_taken;
  assign w_branch_taken = (w_op == OP_BEQ) ? (r_a == r_b) : (r_a != r_b);

  // FSM state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_FETCH;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic plus memory/register-file control per state
  always_comb begin
    w_state_next = r_state;
    w_mem_we     = 1'b0;
    w_mem_addr   = r_pc[AW+1:2];
    w_reg_we     = 1'b0;
    w_reg_waddr  = 5'd0;
    w_reg_wdata  = 32'h0;
    case (r_state)
      S_FETCH: w_state_next = S_DECODE;
      S_DECODE: begin
        case (w_op)
          OP_LW, OP_SW:  w_state_next = S_MEMADR;
          OP_RTYPE:      w_state_next = w_rtype_ok ? S_RTYPEEX : S_FETCH;
          OP_ADDI, OP_ADDIU, OP_SLTI, OP_ANDI,
          OP_ORI, OP_XORI, OP_LUI:
                         w_state_next = S_ITYPEEX;
          OP_BEQ, OP_BNE: w_state_next = S_BRANCH;
          OP_J:          w_state_next = S_JUMP;
          default:       w_state_next = S_FETCH;
        endcase
      end
      S_MEMADR: w_state_next = (w_op == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD: begin
        w_mem_addr   = r_aluout[AW+1:2];
        w_state_next = S_MEMWB;
      end
      S_MEMWB: begin
        w_reg_we     = 1'b1;
        w_reg_waddr  = w_rt;
        w_reg_wdata  = r_mdr;
        w_state_next = S_FETCH;
      end
      S_MEMWR: begin
        w_mem_addr   = r_aluout[AW+1:2];
        w_mem_we     = 1'b1;
        w_state_next = S_FETCH;
      end
      S_RTYPEEX: w_state_next = S_RTYPEWB;
      S_RTYPEWB: begin
        w_reg_we     = 1'b1;
        w_reg_waddr  = w_rd;
        w_reg_wdata  = r_aluout;
        w_state_next = S_FETCH;
      end
      S_ITYPEEX: w_state_next = S_ITYPEWB;
      S_ITYPEWB: begin
        w_reg_we     = 1'b1;
        w_reg_waddr  = w_rt;
        w_reg_wdata  = r_aluout;
        w_state_next = S_FETCH;
      end
      S_BRANCH: w_state_next = S_FETCH;
      S_JUMP:   w_state_next = S_FETCH;
      default:  w_state_next = S_FETCH;
    endcase
  end

  // Datapath registers: PC, IR, operand latches, ALU result, memory data
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pc     <= 32'h0;
      r_ir     <= 32'h0;
      r_a      <= 32'h0;
      r_b      <= 32'h0;
      r_aluout <= 32'h0;
      r_mdr    <= 32'h0;
    end else begin
      case (r_state)
        S_FETCH: begin
          r_ir <= w_mem_rdata;
          r_pc <= r_pc + 32'd4;
        end
        S_DECODE: begin
          r_a      <= w_rs_val;
          r_b      <= w_rt_val;
          // Branch target computed speculatively from the already-advanced PC
          r_aluout <= r_pc + {w_imm_sext[29:0], 2'b00};
        end
        S_MEMADR:  r_aluout <= r_a + w_imm_sext;
        S_MEMRD:   r_mdr    <= w_mem_rdata;
        S_RTYPEEX: r_aluout <= w_alu_r;
        S_ITYPEEX: r_aluout <= w_alu_i;
        S_BRANCH: begin
          if (w_branch_taken) begin
            r_pc <= r_aluout;
          end
        end
        S_JUMP:   r_pc <= {r_pc[31:28], w_target, 2'b00};
        default: ;
      endcase
    end
  end

  // Register file write; $0 stays hard zero
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) begin
        r_regs[i] <= 32'h0;
      end
    end else if (w_reg_we && (w_reg_waddr != 5'd0)) begin
      r_regs[w_reg_waddr] <= w_reg_wdata;
    end
  end

  // Debug views
  generate
    for (genvar gi = 0; gi < 32; gi++) begin : g_regs_debug
      if (gi == 0) begin : g_zero
        assign regs_debug[gi] = 32'h0;
      end else begin : g_reg
        assign regs_debug[gi] = r_regs[gi];
      end
    end
  endgenerate

  assign pc_debug    = r_pc;
  assign instr_debug = r_ir;

endmodule

// File: tb/tb_multi_cycle_cpu.sv
// Directed testbench for multi_cycle_cpu: preloads small programs into
// i_ram.mem, steps the clock and checks registers, PC, IR and memory
// against hand-computed values.
module tb_multi_cycle_cpu;

  logic        clk;
  logic        reset;
  logic [31:0] regs_dbg [0:31];
  logic [31:0] pc_dbg;
  logic [31:0] instr_dbg;

  int n_checks = 0;
  int n_fail   = 0;

  multi_cycle_cpu #(.MEM_DEPTH(1024)) dut (
    .clk         (clk),
    .reset       (reset),
    .regs_debug  (regs_dbg),
    .pc_debug    (pc_dbg),
    .instr_debug (instr_dbg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instruction encoders
  function automatic logic [31:0] enc_r(input int rs, input int rt, input int rd,
                                        input int sh, input int fn);
    return {6'h00, rs[4:0], rt[4:0], rd[4:0], sh[4:0], fn[5:0]};
  endfunction

  function automatic logic [31:0] enc_i(input int op, input int rs, input int rt,
                                        input int imm);
    return {op[5:0], rs[4:0], rt[4:0], imm[15:0]};
  endfunction

  function automatic logic [31:0] enc_j(input int tgt);
    return {6'h02, tgt[25:0]};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
    $display("check %-16s observed %h expected %h", tag, obs, exp);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Hold the core in reset and wipe memory before loading a new program
  task automatic begin_load();
    @(negedge clk);
    reset = 1'b1;
    for (int k = 0; k < 1024; k++) dut.i_ram.mem[k] = 32'h0;
  endtask

  task automatic release_rst();
    @(negedge clk);
    reset = 1'b0;
  endtask

  logic [31:0] exp_pc [1:20];

  initial begin
    reset = 1'b1;
    #2;
    // Reset state
    chk("reset_pc", pc_dbg, 32'h0);
    chk("reset_ir", instr_dbg, 32'h0);
    for (int i = 0; i < 32; i++) chk($sformatf("reset_r%0d", i), regs_dbg[i], 32'h0);

    // Timing: lw at PC 0
    begin_load();
    dut.i_ram.mem[0]  = enc_i(8'h23, 0, 9, 16'h0100);
    dut.i_ram.mem[64] = 32'hCAFEF00D;
    release_rst();
    step(1);
    chk("tim_pc_e1", pc_dbg, 32'd4);
    chk("tim_ir_e1", instr_dbg, 32'h8C090100);
    step(3);
    chk("tim_r9_e4", regs_dbg[9], 32'h0);
    step(1);
    chk("tim_r9_e5", regs_dbg[9], 32'hCAFEF00D);
    chk("tim_pc_e5", pc_dbg, 32'd4);

    // lw/sw program
    begin_load();
    dut.i_ram.mem[0] = enc_i(8'h0D, 0, 8, 16'h1234);
    dut.i_ram.mem[1] = enc_i(8'h2B, 0, 8, 16'h0100);
    dut.i_ram.mem[2] = enc_i(8'h23, 0, 9, 16'h0100);
    dut.i_ram.mem[3] = enc_r(8, 9, 16, 0, 8'h22);
    dut.i_ram.mem[4] = enc_i(8'h09, 0, 2, 10);
    dut.i_ram.mem[5] = enc_r(0, 0, 0, 0, 8'h0C);
    release_rst();
    step(110);
    chk("ls_r8", regs_dbg[8], 32'h1234);
    chk("ls_r9", regs_dbg[9], 32'h1234);
    chk("ls_r16", regs_dbg[16], 32'h0);
    chk("ls_r2", regs_dbg[2], 32'hA);
    chk("ls_mem", dut.i_ram.mem[64], 32'h1234);

    // ALU program
    begin_load();
    dut.i_ram.mem[0]  = enc_i(8'h09, 0, 8, -1);
    dut.i_ram.mem[1]  = enc_i(8'h0D, 0, 9, 16'hFFFF);
    dut.i_ram.mem[2]  = enc_i(8'h0F, 0, 10, 16'h8000);
    dut.i_ram.mem[3]  = enc_r(8, 0, 11, 0, 8'h2A);
    dut.i_ram.mem[4]  = enc_r(8, 0, 12, 0, 8'h2B);
    dut.i_ram.mem[5]  = enc_r(8, 9, 13, 0, 8'h26);
    dut.i_ram.mem[6]  = enc_r(0, 9, 14, 4, 8'h00);
    dut.i_ram.mem[7]  = enc_r(0, 10, 15, 31, 8'h02);
    dut.i_ram.mem[8]  = enc_r(9, 0, 17, 0, 8'h27);
    dut.i_ram.mem[9]  = enc_i(8'h0C, 8, 18, 16'h00F0);
    dut.i_ram.mem[10] = enc_r(10, 10, 19, 0, 8'h20);
    dut.i_ram.mem[11] = enc_i(8'h0A, 8, 20, 0);
    dut.i_ram.mem[12] = enc_i(8'h08, 0, 21, -2);
    dut.i_ram.mem[13] = enc_i(8'h0E, 9, 22, 16'hFF00);
    release_rst();
    step(64);
    chk("alu_addiu", regs_dbg[8], 32'hFFFFFFFF);
    chk("alu_ori", regs_dbg[9], 32'h0000FFFF);
    chk("alu_lui", regs_dbg[10], 32'h80000000);
    chk("alu_slt", regs_dbg[11], 32'h1);
    chk("alu_sltu", regs_dbg[12], 32'h0);
    chk("alu_xor", regs_dbg[13], 32'hFFFF0000);
    chk("alu_sll", regs_dbg[14], 32'h000FFFF0);
    chk("alu_srl", regs_dbg[15], 32'h1);
    chk("alu_nor", regs_dbg[17], 32'hFFFF0000);
    chk("alu_andi", regs_dbg[18], 32'h000000F0);
    chk("alu_add_ovf", regs_dbg[19], 32'h0);
    chk("alu_slti", regs_dbg[20], 32'h1);
    chk("alu_addi", regs_dbg[21], 32'hFFFFFFFE);
    chk("alu_xori", regs_dbg[22], 32'h000000FF);

    // Branch / jump with PC trace
    begin_load();
    dut.i_ram.mem[0] = enc_i(8'h09, 0, 8, 1);
    dut.i_ram.mem[1] = enc_i(8'h04, 0, 0, 1);
    dut.i_ram.mem[2] = enc_i(8'h09, 0, 9, 7);
    dut.i_ram.mem[3] = enc_i(8'h05, 8, 8, 5);
    dut.i_ram.mem[4] = enc_i(8'h09, 0, 10, 3);
    dut.i_ram.mem[5] = enc_j(5);
    exp_pc = '{32'd4, 32'd4, 32'd4, 32'd4, 32'd8, 32'd8, 32'd12, 32'd16, 32'd16, 32'd16,
               32'd20, 32'd20, 32'd20, 32'd20, 32'd24, 32'd24, 32'd20, 32'd24, 32'd24, 32'd20};
    release_rst();
    for (int e = 1; e <= 20; e++) begin
      step(1);
      chk($sformatf("br_pc_e%0d", e), pc_dbg, exp_pc[e]);
    end
    chk("br_r8", regs_dbg[8], 32'd1);
    chk("br_r9_skipped", regs_dbg[9], 32'd0);
    chk("br_r10", regs_dbg[10], 32'd3);

    // $zero stays zero
    begin_load();
    dut.i_ram.mem[0] = enc_i(8'h09, 0, 0, 5);
    dut.i_ram.mem[1] = enc_r(0, 0, 8, 0, 8'h20);
    release_rst();
    step(12);
    chk("zero_r0", regs_dbg[0], 32'h0);
    chk("zero_r8", regs_dbg[8], 32'h0);

    // Reset during MEMWR of an sw
    begin_load();
    dut.i_ram.mem[0]  = enc_i(8'h0D, 0, 8, 16'h0055);
    dut.i_ram.mem[1]  = enc_i(8'h2B, 0, 8, 16'h0100);
    dut.i_ram.mem[64] = 32'hDEAD0000;
    release_rst();
    step(7);
    chk("rst_pc_pre", pc_dbg, 32'd8);
    chk("rst_ir_pre", instr_dbg, 32'hAC080100);
    chk("rst_r8_pre", regs_dbg[8], 32'h55);
    reset = 1'b1;
    #1;
    chk("rst_pc_async", pc_dbg, 32'h0);
    chk("rst_ir_async", instr_dbg, 32'h0);
    chk("rst_r8_async", regs_dbg[8], 32'h0);
    step(1);
    chk("rst_mem_kept", dut.i_ram.mem[64], 32'hDEAD0000);
    release_rst();
    step(20);
    chk("rst_rerun_r8", regs_dbg[8], 32'h55);
    chk("rst_rerun_mem", dut.i_ram.mem[64], 32'h55);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
